// File: rtl/eth_speed_ctrl_pkg.sv
// Shared speed codes, FSM states and helpers for the Ethernet speed controller.
// Imported by the controller top and its divider.
package eth_speed_ctrl_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_QUIESCE,
    ST_APPLY
  } state_e;

  // The reserved code 11 falls back to the slowest rate.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_10M : s;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Programmable clock-enable divider: one strobe every div cycles.
// Sync clear restarts the phase; en gates the strobe without stopping the count.
module clk_en_div #(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] div,
  input  logic          clr,
  input  logic          en,
  output logic          strobe
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= en && (cnt == '0);
      cnt    <= (cnt >= div - DW'(1)) ? '0 : cnt + DW'(1);
    end
  end

endmodule

// File: rtl/eth_speed_ctrl.sv
// Link-speed controller: generates clk_enable/mii_select and switches rate
// only after RX/TX have drained, with a forced switch on idle timeout.
module eth_speed_ctrl
  import eth_speed_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_SPEED    = 2'b10,
  parameter int         DIV_100M       = 5,
  parameter int         DIV_10M        = 50,
  parameter int         DRAIN_STROBES  = 12,
  parameter int         QUIESCE_CYCLES = 16,
  parameter int         IDLE_TIMEOUT   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_speed,
  input  logic       cfg_speed_valid,
  output logic       cfg_speed_ready,
  input  logic       gmii_rx_dv,
  input  logic       tx_busy,
  output logic       clk_enable,
  output logic       mii_select,
  output logic [1:0] speed,
  output logic       change_pending,
  output logic       change_done,
  output logic       change_forced
);

  localparam int DW = $clog2(DIV_10M + 1);
  localparam int IW = $clog2(DRAIN_STROBES + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int QW = $clog2(QUIESCE_CYCLES + 1);

  state_e        state, state_n;
  logic [1:0]    target, target_n, speed_n;
  logic          ready_n, pend_n, done_n, forced_n;
  logic          fflag, fflag_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [QW-1:0] q_cnt, q_n;
  logic [DW-1:0] div;
  logic          div_clr, div_en, idle;

  assign idle   = !gmii_rx_dv && !tx_busy;
  assign div_en = (state_n == ST_RUN) || (state_n == ST_WAIT);

  always_comb begin
    div = DW'(DIV_10M);
    unique case (1'b1)
      (speed == SPEED_1G):   div = DW'(1);
      (speed == SPEED_100M): div = DW'(DIV_100M);
      default:               div = DW'(DIV_10M);
    endcase
  end

  clk_en_div #(.DW(DW)) u_div (
    .clk    (clk),
    .rst    (rst),
    .div    (div),
    .clr    (div_clr),
    .en     (div_en),
    .strobe (clk_enable)
  );

  always_comb begin
    state_n  = state;
    speed_n  = speed;
    target_n = target;
    ready_n  = cfg_speed_ready;
    pend_n   = change_pending;
    done_n   = 1'b0;
    forced_n = 1'b0;
    fflag_n  = fflag;
    idle_n   = idle_cnt;
    to_n     = to_cnt;
    q_n      = q_cnt;
    div_clr  = 1'b0;
    unique case (state)
      ST_RUN: begin
        ready_n = 1'b1;
        if (cfg_speed_valid && cfg_speed_ready) begin
          if (norm_speed(cfg_speed) == speed) begin
            done_n = 1'b1;
          end else begin
            target_n = norm_speed(cfg_speed);
            pend_n   = 1'b1;
            ready_n  = 1'b0;
            idle_n   = '0;
            to_n     = '0;
            fflag_n  = 1'b0;
            state_n  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (to_cnt < TW'(IDLE_TIMEOUT))
          to_n = to_cnt + TW'(1);
        if (clk_enable) begin
          if (!idle)
            idle_n = '0;
          else if (idle_cnt < IW'(DRAIN_STROBES))
            idle_n = idle_cnt + IW'(1);
        end
        // Timeout takes priority so a coincident drain still reports forced.
        if (to_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          fflag_n = 1'b1;
          q_n     = '0;
          state_n = ST_QUIESCE;
        end else if (clk_enable && idle &&
                     idle_cnt == IW'(DRAIN_STROBES - 1)) begin
          q_n     = '0;
          state_n = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        q_n = q_cnt + QW'(1);
        if (q_cnt == QW'(QUIESCE_CYCLES - 1)) begin
          speed_n  = target;
          pend_n   = 1'b0;
          done_n   = 1'b1;
          forced_n = fflag;
          div_clr  = 1'b1;
          state_n  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        ready_n = 1'b1;
        state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RUN;
      speed           <= RESET_SPEED;
      mii_select      <= (RESET_SPEED != SPEED_1G);
      target          <= RESET_SPEED;
      cfg_speed_ready <= 1'b1;
      change_pending  <= 1'b0;
      change_done     <= 1'b0;
      change_forced   <= 1'b0;
      fflag           <= 1'b0;
      idle_cnt        <= '0;
      to_cnt          <= '0;
      q_cnt           <= '0;
    end else begin
      state           <= state_n;
      speed           <= speed_n;
      mii_select      <= (speed_n != SPEED_1G);
      target          <= target_n;
      cfg_speed_ready <= ready_n;
      change_pending  <= pend_n;
      change_done     <= done_n;
      change_forced   <= forced_n;
      fflag           <= fflag_n;
      idle_cnt        <= idle_n;
      to_cnt          <= to_n;
      q_cnt           <= q_n;
    end
  end

endmodule
